// File: rtl/fp_div_arbiter_if.sv
// Request, divider and response bundle between the ALU issue ports, the arbiter
// and the shared FloatingDivision datapath.
interface fp_div_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         div_a;
    logic [WIDTH-1:0]         div_b;
    logic [WIDTH-1:0]         div_result;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_result;
    logic                     resp_ready;
    logic                     busy;
    logic [CNT_W-1:0]         op_count;

    // Requesters, divider and consumer side
    modport master (
        output req_valid, req_a, req_b, div_result, resp_ready,
        input  req_ready, div_a, div_b, resp_valid, resp_id, resp_result, busy, op_count
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, div_result, resp_ready,
        output req_ready, div_a, div_b, resp_valid, resp_id, resp_result, busy, op_count
    );
endinterface

// File: rtl/fp_div_arbiter.sv
// Round-robin front end sharing one combinational FloatingDivision instance
// between NUM_REQ issue ports; holds operands for SETTLE_CYCLES, then presents
// the tagged quotient until the consumer takes it.
//
// state  | meaning
// IDLE   | no operation in flight; round-robin grant offered to requesters
// SETTLE | operands held on div_a/div_b while the divider output settles
// RESP   | quotient held on resp_result/resp_id until resp_ready
module fp_div_arbiter #(
    parameter int WIDTH         = 32,
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_div_arbiter_if.slave bus
);

    localparam int              SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;

    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic               grant_found;
    logic [NUM_REQ-1:0] req_ready_c;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_idx   = last_grant_q;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grant is only offered while idle, so it never coincides with a response
    always_comb begin
        req_ready_c = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        div_a_d       = div_a_q;
        div_b_d       = div_b_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        op_count_d    = op_count_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    div_a_d      = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
                    div_b_d      = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
                    resp_id_d    = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    resp_result_d = bus.div_result;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
    end

    // State and output registers; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= LAST_INIT;
            cnt_q         <= '0;
            div_a_q       <= '0;
            div_b_q       <= '0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            op_count_q    <= '0;
            resp_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            div_a_q       <= div_a_d;
            div_b_q       <= div_b_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            op_count_q    <= op_count_d;
            resp_valid_q  <= resp_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.busy        = busy_q;
    assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: a settling divider model, a grant/response
// scoreboard, and one task per scenario. A second instance with a 2-bit
// counter shadows the first to observe op_count wrap.
module tb_fp_div_arbiter;
    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int SETTLE  = 2;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_div_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();
    fp_div_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(2))     bus_w ();

    fp_div_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
                     .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    fp_div_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
                     .SETTLE_CYCLES(SETTLE), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w.slave));

    assign bus_w.req_valid  = bus.req_valid;
    assign bus_w.req_a      = bus.req_a;
    assign bus_w.req_b      = bus.req_b;
    assign bus_w.resp_ready = bus.resp_ready;
    assign bus_w.div_result = bus.div_result;

    int n_checks = 0;
    int n_fail   = 0;

    // Known quotients; other pairs get an arbitrary but deterministic pattern
    function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40000000}: return 32'h40400000;
            {32'h40600000, 32'h40900000}: return 32'h3F471C72;
            {32'h40800000, 32'h00000000}: return 32'h7F800000;
            {32'h7FC00000, 32'h3F800000}: return 32'h7FC00000;
            {32'h41200000, 32'h40A00000}: return 32'h40000000;
            {32'hC1000000, 32'h40000000}: return 32'hC0800000;
            {32'h3F800000, 32'h40800000}: return 32'h3E800000;
            default: return a ^ {b[15:0], b[31:16]} ^ 32'h0F0F5A5A;
        endcase
    endfunction

    // Divider output is garbage until its inputs have been stable SETTLE cycles
    int          held = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    always @(negedge clk) begin
        if (bus.div_a !== last_a || bus.div_b !== last_b) held = 1;
        else if (held < 1000) held++;
        last_a = bus.div_a;
        last_b = bus.div_b;
    end
    assign bus.div_result = (held >= SETTLE) ? fdiv_model(bus.div_a, bus.div_b) : 32'hDEADBEEF;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] res;
    } exp_t;
    exp_t             sb_q[$];
    logic [ID_W-1:0]  m_last = ID_W'(NUM_REQ - 1);
    logic [CNT_W-1:0] exp_cnt = '0;

    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [ID_W-1:0] last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NUM_REQ;
            if (v[idx]) return ID_W'(idx);
        end
        return last;
    endfunction

    // Scoreboard: push on grant handshake, pop and compare on response handshake
    always @(negedge clk) begin
        exp_t            e;
        logic [ID_W-1:0] g;
        if (!rst_n) begin
            sb_q.delete();
            m_last  = ID_W'(NUM_REQ - 1);
            exp_cnt = '0;
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got id=%0d result=%h, required no response",
                             bus.resp_id, bus.resp_result);
                end else begin
                    e = sb_q.pop_front();
                    if (bus.resp_id !== e.id || bus.resp_result !== e.res) begin
                        n_fail++;
                        $display("FAIL sb_resp: got id=%0d result=%h, required id=%0d result=%h",
                                 bus.resp_id, bus.resp_result, e.id, e.res);
                    end
                end
                n_checks++;
                if (bus.op_count !== exp_cnt || bus_w.op_count !== exp_cnt[1:0]) begin
                    n_fail++;
                    $display("FAIL sb_op_count: got %0d/%0d, required %0d/%0d",
                             bus.op_count, bus_w.op_count, exp_cnt, exp_cnt[1:0]);
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (|(bus.req_valid & bus.req_ready)) begin
                g = rr_pick(bus.req_valid, m_last);
                e.id  = g;
                e.res = fdiv_model(bus.req_a[int'(g)*WIDTH +: WIDTH], bus.req_b[int'(g)*WIDTH +: WIDTH]);
                sb_q.push_back(e);
                m_last = g;
            end
        end
    end

    int g_ids[8];
    int g_tms[8];
    int g_cnt;

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[r*WIDTH +: WIDTH] = a;
        bus.req_b[r*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy && sb_q.size() == 0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Records n grants (index and cycle) then drops all req_valid after the last one
    task automatic collect_grants(input int n);
        int cyc;
        g_cnt = 0;
        cyc   = 0;
        while (g_cnt < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (|(bus.req_valid & bus.req_ready)) begin
                for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) g_ids[g_cnt] = i;
                g_tms[g_cnt] = cyc;
                g_cnt++;
            end
        end
        drive_edge();
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        drive_edge();
        rst_n = 1'b0;
        drive_edge();
        drive_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b busy=%b, required 0 0", bus.resp_valid, bus.busy);
        end
        n_checks++;
        if (bus.div_a !== '0 || bus.div_b !== '0) begin
            n_fail++;
            $display("FAIL reset_div: got a=%h b=%h, required 0 0", bus.div_a, bus.div_b);
        end
        n_checks++;
        if (bus.resp_result !== '0 || bus.resp_id !== '0 || bus.op_count !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got result=%h id=%0d cnt=%0d, required 0 0 0",
                     bus.resp_result, bus.resp_id, bus.op_count);
        end
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0000", bus.req_ready);
        end
    endtask

    task automatic test_single();
        int lat;
        drive_edge();
        set_ops(1, 32'h40C00000, 32'h40000000);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_grant: got %b, required 0010", bus.req_ready);
        end
        drive_edge();
        bus.req_valid = '0;
        wait_resp(lat);
        n_checks++;
        if (lat != SETTLE + 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d, required %0d", lat, SETTLE + 1);
        end
        n_checks++;
        if (bus.resp_id !== 2'd1 || bus.resp_result !== 32'h40400000) begin
            n_fail++;
            $display("FAIL single_resp: got id=%0d result=%h, required 1 40400000",
                     bus.resp_id, bus.resp_result);
        end
        @(negedge clk);
        n_checks++;
        if (bus.op_count !== 16'd1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got cnt=%0d busy=%b, required 1 0", bus.op_count, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        bit ok;
        do_reset();
        set_ops(0, 32'h40600000, 32'h40900000);
        set_ops(1, 32'h40800000, 32'h00000000);
        set_ops(2, 32'h7FC00000, 32'h3F800000);
        set_ops(3, 32'h41200000, 32'h40A00000);
        bus.req_valid = 4'b1111;
        collect_grants(5);
        n_checks++;
        if (g_cnt != 5) begin
            n_fail++;
            $display("FAIL b2b_grant_count: got %0d, required 5", g_cnt);
        end
        for (int i = 0; i < g_cnt; i++) begin
            n_checks++;
            if (g_ids[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %0d, required %0d", i, g_ids[i], exp_seq[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (g_tms[i] - g_tms[i-1] != SETTLE + 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d, required %0d",
                             i, g_tms[i] - g_tms[i-1], SETTLE + 2);
                end
            end
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL b2b_drain: got busy=%b pending=%0d, required idle 0", bus.busy, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit               ok;
        int               lat;
        logic [ID_W-1:0]  id0;
        logic [WIDTH-1:0] res0;
        drive_edge();
        bus.resp_ready = 1'b0;
        set_ops(3, 32'hC1000000, 32'h40000000);
        bus.req_valid = 4'b1000;
        wait_grant(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_grant: got no grant, required grant of 3");
        end
        drive_edge();
        set_ops(0, 32'h3F800000, 32'h40800000);
        bus.req_valid = 4'b0001;
        wait_resp(lat);
        id0  = bus.resp_id;
        res0 = bus.resp_result;
        n_checks++;
        if (id0 !== 2'd3 || res0 !== 32'hC0800000) begin
            n_fail++;
            $display("FAIL bp_resp: got id=%0d result=%h, required 3 c0800000", id0, res0);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.req_ready !== 4'b0000 ||
                bus.resp_id !== id0 || bus.resp_result !== res0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b id=%0d result=%h, required 1 0000 %0d %h",
                         i, bus.resp_valid, bus.req_ready, bus.resp_id, bus.resp_result, id0, res0);
            end
        end
        drive_edge();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_accept: got valid=%b ready=%b, required 1 0000", bus.resp_valid, bus.req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_next_grant: got %b, required 0001", bus.req_ready);
        end
        drive_edge();
        bus.req_valid = '0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_drain: got busy=%b pending=%0d, required idle 0", bus.busy, sb_q.size());
        end
    endtask

    task automatic test_fairness();
        int exp_seq[3] = '{2, 0, 2};
        bit ok;
        drive_edge();
        set_ops(0, 32'h41200000, 32'h40A00000);
        set_ops(2, 32'h40C00000, 32'h40000000);
        bus.req_valid = 4'b0001;
        wait_grant(ok);
        drive_edge();
        bus.req_valid = '0;
        wait_idle(ok);
        drive_edge();
        bus.req_valid = 4'b0101;
        collect_grants(3);
        n_checks++;
        if (g_cnt != 3) begin
            n_fail++;
            $display("FAIL fair_grant_count: got %0d, required 3", g_cnt);
        end
        for (int i = 0; i < g_cnt; i++) begin
            n_checks++;
            if (g_ids[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got %0d, required %0d", i, g_ids[i], exp_seq[i]);
            end
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fair_drain: got busy=%b pending=%0d, required idle 0", bus.busy, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        drive_edge();
        set_ops(2, 32'h41200000, 32'h40A00000);
        bus.req_valid = 4'b0100;
        wait_grant(ok);
        drive_edge();
        bus.req_valid = '0;
        rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.op_count !== '0 ||
            bus.div_a !== '0 || bus.div_b !== '0 || bus.resp_result !== '0 || bus.resp_id !== '0) begin
            n_fail++;
            $display("FAIL rmid_values: got busy=%b valid=%b cnt=%0d a=%h b=%h result=%h id=%0d, required all 0",
                     bus.busy, bus.resp_valid, bus.op_count, bus.div_a, bus.div_b,
                     bus.resp_result, bus.resp_id);
        end
        seen = 1'b0;
        for (int i = 0; i < SETTLE + 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rmid_no_resp: got resp_valid=1, required 0");
        end
        drive_edge();
        set_ops(0, 32'h40600000, 32'h40900000);
        set_ops(1, 32'h40800000, 32'h00000000);
        set_ops(3, 32'h7FC00000, 32'h3F800000);
        bus.req_valid = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rmid_first_grant: got %b, required 0001", bus.req_ready);
        end
        drive_edge();
        bus.req_valid = '0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmid_drain: got busy=%b pending=%0d, required idle 0", bus.busy, sb_q.size());
        end
    endtask

    task automatic test_wrap();
        int          exp_w[5] = '{1, 2, 3, 0, 1};
        logic [31:0] wa[5]    = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h41200000, 32'h12345678};
        logic [31:0] wb[5]    = '{32'h40000000, 32'h40800000, 32'h40000000, 32'h40A00000, 32'h9ABCDEF0};
        bit ok;
        int lat;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_edge();
            set_ops(i % NUM_REQ, wa[i], wb[i]);
            bus.req_valid = '0;
            bus.req_valid[i % NUM_REQ] = 1'b1;
            wait_grant(ok);
            drive_edge();
            bus.req_valid = '0;
            wait_resp(lat);
            @(negedge clk);
            n_checks++;
            if (int'(bus_w.op_count) != exp_w[i]) begin
                n_fail++;
                $display("FAIL wrap_count[%0d]: got %0d, required %0d", i, bus_w.op_count, exp_w[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_wrap();
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
